// File: rtl/row_reduce_accumulator.sv
// Row reducer: NI-lane chunks summed by a pipelined adder tree,
// then accumulated per row with a sticky signed-overflow flag.
// Ports:
//   clk, rst          clock, async active-high reset
//   start, row_len    begin a row of row_len chunks (IDLE only)
//   in_valid/ready    chunk handshake, in_data = NI lanes of W bits
//   out_valid/ready   result handshake, out_data/out_ovf = row sum
//   busy              FSM not in IDLE
module row_reduce_accumulator #(
  parameter int NI    = 8,
  parameter int W     = 32,
  parameter int ACC_W = 48,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] row_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NI*W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int L = $clog2(NI);
  localparam logic [L:1] LOW_MASK =
    L'((64'd1 << (L - 1)) - 64'd1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HOLD
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] rem_q;
  logic [L:1]       vld_q;
  logic             first_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;

  logic take_start;
  logic in_hs;
  logic tree_v;
  logic early_v;
  logic last_sum;

  logic signed [ACC_W-1:0] tsum;
  logic        [ACC_W-1:0] acc_add;
  logic                    ovf_add;

  // Level j holds NI>>j pairwise sums of width W+j,
  // so no level can overflow.
  for (genvar j = 1; j <= L; j++) begin : lvl
    localparam int N  = NI >> j;
    localparam int SW = W + j;

    logic signed [SW-1:0] a   [N];
    logic signed [SW-1:0] b   [N];
    logic signed [SW-1:0] s_q [N];

    if (j == 1) begin : g_src
      always_comb begin
        for (int i = 0; i < N; i++) begin
          a[i] = SW'($signed(in_data[(2*i)*W +: W]));
          b[i] = SW'($signed(in_data[(2*i+1)*W +: W]));
        end
      end
    end else begin : g_src
      always_comb begin
        for (int i = 0; i < N; i++) begin
          a[i] = SW'(lvl[j-1].s_q[2*i]);
          b[i] = SW'(lvl[j-1].s_q[2*i+1]);
        end
      end
    end

    always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
        s_q[i] <= a[i] + b[i];
      end
    end
  end

  assign take_start = (state_q == IDLE) && start;
  assign in_hs      = in_valid && in_ready;
  assign tree_v     = vld_q[L];
  assign early_v    = |(vld_q & LOW_MASK);

  // No chunks enter during DRAIN, so the last sum is the one
  // leaving the tree with every earlier level empty.
  assign last_sum = (state_q == DRAIN) && tree_v && !early_v;

  assign tsum    = ACC_W'(lvl[L].s_q[0]);
  assign acc_add = acc_q + tsum;
  assign ovf_add = (acc_q[ACC_W-1] == tsum[ACC_W-1]) &&
                   (acc_add[ACC_W-1] != acc_q[ACC_W-1]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (row_len != '0) ? RUN : HOLD;
        end
      end
      RUN: begin
        if (in_hs && rem_q == CNT_W'(1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_sum) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      vld_q   <= '0;
      rem_q   <= '0;
      first_q <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vld_q[1] <= in_hs;
      for (int j = 2; j <= L; j++) begin
        vld_q[j] <= vld_q[j-1];
      end
      if (take_start) begin
        rem_q   <= row_len;
        acc_q   <= '0;
        ovf_q   <= 1'b0;
        first_q <= 1'b1;
      end else begin
        if (in_hs) begin
          rem_q <= rem_q - CNT_W'(1);
        end
        if (tree_v) begin
          first_q <= 1'b0;
          // First sum of a row loads; later sums add.
          if (first_q) begin
            acc_q <= tsum;
          end else begin
            acc_q <= acc_add;
            if (ovf_add) begin
              ovf_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign in_ready  = (state_q == RUN);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;

endmodule

// File: doc/row_reduce_accumulator.md
ROW_REDUCE_ACCUMULATOR -- requirements
Module: row_reduce_accumulator

Interface
REQ-001 SHALL have parameter NI, default 8: lanes per chunk; a power of two, 2..32; L = log2(NI).
REQ-002 SHALL have parameter W, default 32: signed two's-complement lane width.
REQ-003 SHALL have parameter ACC_W, default 48: accumulator/result width; ACC_W >= W+L.
REQ-004 SHALL have parameter CNT_W, default 16: chunk-count width.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port start, input, 1: begin a row; sampled only in IDLE.
REQ-008 SHALL have port row_len, input, CNT_W: chunks in the row; latched when start is accepted.
REQ-009 SHALL have port in_valid, input, 1: chunk present.
REQ-010 SHALL have port in_ready, output, 1: chunk accepted this cycle when in_valid=1.
REQ-011 SHALL have port in_data, input, NI*W: lane i occupies bits [i*W+W-1 : i*W].
REQ-012 SHALL have port out_valid, output, 1: result available.
REQ-013 SHALL have port out_ready, input, 1: result consumed when out_valid=1.
REQ-014 SHALL have port out_data, output, ACC_W: row sum.
REQ-015 SHALL have port out_ovf, output, 1: sticky signed-overflow flag for the row.
REQ-016 SHALL have port busy, output, 1: state is not IDLE.

Function
REQ-017 SHALL implement four FSM states: IDLE, RUN, DRAIN, HOLD.
REQ-018 IDLE: when start=1 and row_len>0, SHALL latch row_len, clear the accumulator and out_ovf, and go to RUN.
REQ-019 IDLE: when start=1 and row_len=0, SHALL go to HOLD with out_data=0 and out_ovf=0, accepting no chunks.
REQ-020 SHALL drive in_ready=1 only in RUN; the chunk handshake is in_valid & in_ready at a rising edge.
REQ-021 RUN: SHALL decrement the remaining-chunk count on each accepted chunk and go to DRAIN on the edge that accepts the last chunk.
REQ-022 SHALL sign-extend every lane before any addition.
REQ-023 SHALL reduce lanes through a pipelined adder tree of L registered levels; level j holds pairwise sums of width W+j.
REQ-024 The adder tree SHALL never overflow.
REQ-025 Each tree level SHALL carry a valid bit, so in_valid gaps propagate as bubbles.
REQ-026 A chunk accepted at edge k SHALL appear in tree level j at edge k+j-1, for j = 1..L.
REQ-027 The accumulator SHALL update at edge k+L.
REQ-028 On the row's first valid tree output, the accumulator SHALL load the sum (no add to a stale value); on later outputs it SHALL add.
REQ-029 Accumulator addition SHALL wrap modulo 2^ACC_W.
REQ-030 out_ovf SHALL be set on any signed overflow of an accumulator add and SHALL stay set until the next accepted start.
REQ-031 DRAIN: SHALL go to HOLD at the edge where the last chunk's sum enters the accumulator.
REQ-032 out_valid SHALL rise at edge k+L for the last chunk.
REQ-033 HOLD: out_valid=1; out_data and out_ovf SHALL be held stable until out_valid & out_ready, then go to IDLE.
REQ-034 start SHALL be ignored outside IDLE, including the cycle of the out handshake.
REQ-035 The earliest next start SHALL be accepted one cycle after the return to IDLE.
REQ-036 out_data and out_ovf SHALL keep their last values in IDLE.

Reset
REQ-037 While rst=1, SHALL asynchronously force state IDLE, clear all tree valid bits, and clear the chunk counter.
REQ-038 While rst=1, outputs SHALL be in_ready=0, out_valid=0, busy=0, out_data=0, out_ovf=0.
REQ-039 Reset mid-row SHALL discard all partial sums; no result is produced for the aborted row.
REQ-040 After rst falls, the first start SHALL operate normally.

Verification (NI=8, W=32, ACC_W=48 unless stated)
REQ-041 SHALL cover: start, row_len=1, lanes 1..8 accepted at edge k -> out_valid at edge k+3, out_data=36, out_ovf=0.
REQ-042 SHALL cover: row_len=3, every lane -1, with 2-cycle in_valid gaps between chunks -> out_data=-24 (0xFFFFFFFFFFE8), with exactly 3 handshakes.
REQ-043 SHALL cover: result pending with out_ready=0 for 5 cycles, start pulsed -> out_data stable, in_ready=0, start ignored; out_ready=1 -> IDLE next edge.
REQ-044 SHALL cover: ACC_W=35, row_len=2, all lanes 0x7FFFFFFF -> out_data=-16, out_ovf=1; the next row with lanes 0 -> out_ovf=0.
REQ-045 SHALL cover: row_len=4 with rst pulsed after 2 chunks -> all outputs 0 immediately; a following row_len=1 with lanes 1..8 -> out_data=36.
REQ-046 SHALL cover: start with row_len=0 -> HOLD next edge, out_valid=1, out_data=0, in_ready never 1.
